// File: rtl/galc_pkg.sv
// Shared state encoding and default geometry for the GALC frame sequencer.
package galc_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_FLUSH,
    ST_LATCH,
    ST_DONE
  } galc_state_t;

endpackage

// File: rtl/galc_xy_cnt.sv
// Raster x/y pixel counter: advances on en, wraps per line and per frame,
// and flags the last pixel of the frame.
module galc_xy_cnt
  import galc_pkg::*;
#(
  parameter  int IMG_W = IMG_W_DEF,
  parameter  int IMG_H = IMG_H_DEF,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          last
);

  logic x_end, y_end;

  assign x_end = (x_cnt == XW'(IMG_W - 1));
  assign y_end = (y_cnt == YW'(IMG_H - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (clr) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (en) begin
      if (x_end) begin
        x_cnt <= '0;
        y_cnt <= y_end ? '0 : y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

endmodule

// File: rtl/galc_frame_ctrl.sv
// Frame sequencer for the GALC datapath: scans the raster, enables GALC on valid
// 3x3 windows, drains its pipeline and latches the atmospheric light.
// Optional stall timeout: define GALC_CTRL_TIMEOUT_EN.
module galc_frame_ctrl
  import galc_pkg::*;
#(
  parameter  int IMG_W     = IMG_W_DEF,
  parameter  int IMG_H     = IMG_H_DEF,
  parameter  int FLUSH_CYC = 2,
`ifdef GALC_CTRL_TIMEOUT_EN
  parameter  int TIMEOUT   = 4096,
`endif
  localparam int XW        = $clog2(IMG_W),
  localparam int YW        = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] arg_in,
  input  logic [PIX_W-1:0] agg_in,
  input  logic [PIX_W-1:0] agb_in,
  output logic             galc_clr,
  output logic             galc_rdy,
  output logic             galc_rd,
  output logic             win_hold,
  output logic [XW-1:0]    x_cnt,
  output logic [YW-1:0]    y_cnt,
  output logic             busy,
  output logic             done,
  output logic [PIX_W-1:0] atm_r,
  output logic [PIX_W-1:0] atm_g,
  output logic [PIX_W-1:0] atm_b,
  output logic             atm_valid,
  output logic             err
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  galc_state_t   state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic          start_ok, cnt_en, last_pix, win_ok, flush_last, stall_hit;

  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign cnt_en     = (state == ST_SCAN) && pix_valid;
  assign win_ok     = (x_cnt >= XW'(2)) && (y_cnt >= YW'(2));
  assign flush_last = (flush_cnt == FW'(FLUSH_CYC - 1));

  galc_xy_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (cnt_en),
    .x_cnt (x_cnt),
    .y_cnt (y_cnt),
    .last  (last_pix)
  );

`ifdef GALC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_cnt;
  logic          err_q;

  assign stall_hit = (state == ST_SCAN) && !pix_valid && (stall_cnt == TW'(TIMEOUT - 1));
  assign err       = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state != ST_SCAN) || pix_valid) stall_cnt <= '0;
      else                                 stall_cnt <= stall_cnt + TW'(1);
      if (start_ok)       err_q <= 1'b0;
      else if (stall_hit) err_q <= 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    galc_clr  = 1'b0;
    galc_rdy  = 1'b0;
    galc_rd   = 1'b0;
    win_hold  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        galc_clr  = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        busy     = 1'b1;
        galc_rdy = pix_valid && win_ok;
        galc_rd  = pix_valid && win_ok;
        if (stall_hit)               state_nxt = ST_IDLE;
        else if (pix_valid && last_pix) state_nxt = ST_FLUSH;
      end
      // Last window is replayed; re-applying it cannot change a running max.
      ST_FLUSH: begin
        busy     = 1'b1;
        win_hold = 1'b1;
        galc_rdy = 1'b1;
        galc_rd  = 1'b1;
        if (flush_last) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_CLEAR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      atm_r     <= '0;
      atm_g     <= '0;
      atm_b     <= '0;
      atm_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FW'(1) : '0;
      if (start_ok) begin
        atm_valid <= 1'b0;
      end else if (state == ST_LATCH) begin
        atm_r     <= arg_in;
        atm_g     <= agg_in;
        atm_b     <= agb_in;
        atm_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_galc_frame_ctrl.sv
// Directed bench for galc_frame_ctrl on a 4x4 frame with a small GALC
// max-dark-channel model and enable/result scoreboards.
module tb_galc_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int FC = 2;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [7:0] arg_in, agg_in, agb_in;
  logic       galc_clr, galc_rdy, galc_rd, win_hold, busy, done, atm_valid, err;
  logic [1:0] x_cnt, y_cnt;
  logic [7:0] atm_r, atm_g, atm_b;

  int checks = 0, errors = 0;
  int clr_cnt = 0, done_cnt = 0, en_cnt = 0, flush_cnt = 0;

  logic [23:0] cand = '0, s1 = '0, mx = '0;
  logic [3:0]  exp_xy_q[$];
  logic [23:0] exp_atm_q[$];

  always #5 clk = ~clk;

  galc_frame_ctrl #(
    .IMG_W     (W),
    .IMG_H     (H),
    .FLUSH_CYC (FC)
`ifdef GALC_CTRL_TIMEOUT_EN
    , .TIMEOUT (8)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pix_valid (pix_valid),
    .arg_in    (arg_in),
    .agg_in    (agg_in),
    .agb_in    (agb_in),
    .galc_clr  (galc_clr),
    .galc_rdy  (galc_rdy),
    .galc_rd   (galc_rd),
    .win_hold  (win_hold),
    .x_cnt     (x_cnt),
    .y_cnt     (y_cnt),
    .busy      (busy),
    .done      (done),
    .atm_r     (atm_r),
    .atm_g     (atm_g),
    .atm_b     (atm_b),
    .atm_valid (atm_valid),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dark(input logic [23:0] p);
    logic [7:0] m;
    m = p[23:16];
    if (p[15:8] < m) m = p[15:8];
    if (p[7:0] < m)  m = p[7:0];
    return m;
  endfunction

  // Window candidate RGB per pixel index; non-window pixels are bright so any
  // stray enable would corrupt the result.
  function automatic logic [23:0] pix(input int sel, input int idx);
    case (idx)
      10:      return 24'h1E2814;
      11:      return 24'h5A5046;
      14:      return 24'h64640A;
      15:      return (sel == 0) ? 24'h3C3237 : 24'h786E64;
      default: return 24'hC8C8C8;
    endcase
  endfunction

  // Two-stage GALC model: candidate register then running max of dark channel.
  always @(posedge clk) begin
    if (galc_clr) begin
      s1 <= '0;
      mx <= '0;
    end else if (galc_rdy) begin
      s1 <= cand;
      if (dark(s1) > dark(mx)) mx <= s1;
    end
  end
  assign {arg_in, agg_in, agb_in} = mx;

  always @(negedge clk) begin
    if (reset) begin
      if (galc_clr) clr_cnt++;
      if (galc_rdy || galc_rd) check("rd_eq_rdy", {30'd0, galc_rd, galc_rdy}, 32'd3);
      if (galc_rdy) begin
        en_cnt++;
        if (win_hold) begin
          flush_cnt++;
        end else begin
          check("en_expected", exp_xy_q.size() > 0, 1);
          check("en_pix_valid", pix_valid, 1);
          if (exp_xy_q.size() > 0) check("en_xy", {x_cnt, y_cnt}, exp_xy_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", exp_atm_q.size() > 0, 1);
        check("done_atm_valid", atm_valid, 1);
        if (exp_atm_q.size() > 0) check("atm_rgb", {atm_r, atm_g, atm_b}, exp_atm_q.pop_front());
      end
    end
  end

  task automatic start_frame(input logic [23:0] exp_atm);
    exp_atm_q.push_back(exp_atm);
    clr_cnt = 0; done_cnt = 0; en_cnt = 0; flush_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clear_clr", galc_clr, 1);
    check("clear_atm_valid_low", atm_valid, 0);
    check("clear_busy", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input int sel, input bit gaps, input int glitch_at, input int stop_at);
    for (int i = 0; i < W * H; i++) begin
      if (i == stop_at) begin
        pix_valid = 1'b0;
        return;
      end
      pix_valid = 1'b1;
      cand      = pix(sel, i);
      if ((i % W) >= 2 && (i / W) >= 2) exp_xy_q.push_back({2'(i % W), 2'(i / W)});
      start = (i == glitch_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (gaps && i != W * H - 1) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int lat;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", lat, FC + 2);
    check("done_busy_low", busy, 0);
    @(negedge clk); #1;
    check("done_count", done_cnt, 1);
    check("enable_count", en_cnt, (W - 2) * (H - 2) + FC);
    check("flush_count", flush_cnt, FC);
    check("xy_queue_drained", exp_xy_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_ctrl", {galc_clr, galc_rdy, galc_rd, win_hold, busy, done, atm_valid, err, x_cnt, y_cnt}, 0);
    check("reset_atm", {atm_r, atm_g, atm_b}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Frame 1: continuous pixels.
    start_frame(24'h5A5046);
    feed(0, 1'b0, -1, -1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("atm_valid_hold", atm_valid, 1);
    check("atm_hold", {atm_r, atm_g, atm_b}, 24'h5A5046);

    // Frame 2: pix_valid toggled.
    start_frame(24'h5A5046);
    feed(0, 1'b1, -1, -1);
    wait_done();

    // Frame 3: start pulsed mid-SCAN must be ignored.
    start_frame(24'h5A5046);
    feed(0, 1'b0, 5, -1);
    wait_done();
    repeat (12) @(posedge clk);
    #1;
    check("glitch_single_done", done_cnt, 1);
    check("glitch_idle", busy, 0);

    // Frame 4: reset at pixel 9, then a full frame.
    start_frame(24'h5A5046);
    feed(0, 1'b0, -1, 9);
    check("pre_reset_xy", {x_cnt, y_cnt}, {2'd1, 2'd2});
    #2 reset = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", {galc_clr, galc_rdy, galc_rd, win_hold, busy, done, atm_valid, err, x_cnt, y_cnt}, 0);
    check("midreset_atm", {atm_r, atm_g, atm_b}, 0);
    exp_atm_q.delete();
    exp_xy_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    start_frame(24'h5A5046);
    feed(0, 1'b0, -1, -1);
    wait_done();
    check("restart_clr_once", clr_cnt, 1);

    // Frames 5/6: back-to-back, start issued in DONE.
    start_frame(24'h5A5046);
    feed(0, 1'b0, -1, -1);
    wait_done();
    start_frame(24'h786E64);
    feed(1, 1'b0, -1, -1);
    wait_done();
    check("b2b_atm_replaced", {atm_r, atm_g, atm_b}, 24'h786E64);

`ifdef GALC_CTRL_TIMEOUT_EN
    start_frame(24'h000000);
    feed(0, 1'b0, -1, 6);
    repeat (8) @(posedge clk);
    #1;
    check("timeout_err", err, 1);
    check("timeout_idle", busy, 0);
    check("timeout_atm_valid", atm_valid, 0);
    check("timeout_no_done", done_cnt, 0);
    exp_atm_q.delete();
    exp_xy_q.delete();
`else
    check("err_tied_low", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
